fifo_access_ctrl: RTL and testbench

//  Sequences the 4-bit FIFO from the board's read/write buttons and data switches.

---
 rtl/fifo_access_ctrl_if.sv | 30 +++
 rtl/fifo_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fifo_access_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_access_ctrl_if.sv
// FIFO-side bus of fifo_access_ctrl: write/read strobes, write data, status flags and read data.
// The controller takes the master modport; the FIFO (or its model) takes the slave modport.
interface fifo_access_ctrl_if #(
  parameter int DATA_W = 4
);
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_wr_en;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_din;

  modport master (
    input  fifo_full,
    input  fifo_empty,
    input  fifo_dout,
    output fifo_wr_en,
    output fifo_rd_en,
    output fifo_din
  );

  modport slave (
    output fifo_full,
    output fifo_empty,
    output fifo_dout,
    input  fifo_wr_en,
    input  fifo_rd_en,
    input  fifo_din
  );
endinterface

// File: rtl/fifo_access_ctrl.sv
// Button-driven FIFO sequencer: synchronises and debounces the read/write buttons, arbitrates
// simultaneous presses, issues single-cycle FIFO strobes and captures the read data.
module fifo_access_ctrl #(
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RD_LATENCY      = 1
) (
  input  logic               clk_5M,
  input  logic               reset,
  input  logic               btn_read,
  input  logic               btn_write,
  input  logic [DATA_W-1:0]  sw_din,
  fifo_access_ctrl_if.master fifo,
  output logic [DATA_W-1:0]  dout_latched,
  output logic               dout_valid,
  output logic               err_overflow,
  output logic               err_underflow,
  output logic               busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic GRANT_WRITE = 1'b0;
  localparam logic GRANT_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    RELEASE
  } state_t;

  // Index 0 is the write button, index 1 the read button.
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;

  assign btn_raw = {btn_read, btn_write};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             stable_q;
      logic             stable_d;
      logic             press_q;
      logic             press_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Count consecutive cycles where the synced level disagrees with the accepted level;
      // any agreeing cycle restarts the count.
      always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            press_d  = sync2_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk_5M) begin
        if (reset) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          stable_q <= 1'b0;
          press_q  <= 1'b0;
          cnt_q    <= '0;
        end else begin
          sync1_q  <= btn_raw[gi];
          sync2_q  <= sync1_q;
          stable_q <= stable_d;
          press_q  <= press_d;
          cnt_q    <= cnt_d;
        end
      end

      assign btn_level[gi] = stable_q;
      assign btn_press[gi] = press_q;
    end
  endgenerate

  state_t            state_q;
  logic              last_grant_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;
  logic              ovf_q;
  logic              unf_q;
  logic [LAT_W-1:0]  lat_q;
  logic              grant_read;

  // A lone press wins outright; a simultaneous pair goes to the side not granted last time.
  assign grant_read = btn_press[1] & (~btn_press[0] | (last_grant_q == GRANT_WRITE));

  always_ff @(posedge clk_5M) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_READ;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      din_q        <= '0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      lat_q        <= '0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|btn_press) begin
            if (&btn_press) begin
              last_grant_q <= grant_read;
            end
            if (grant_read) begin
              if (fifo.fifo_empty) begin
                unf_q   <= 1'b1;
                state_q <= RELEASE;
              end else begin
                rd_en_q <= 1'b1;
                state_q <= RD;
              end
            end else begin
              if (fifo.fifo_full) begin
                ovf_q   <= 1'b1;
                state_q <= RELEASE;
              end else begin
                din_q   <= sw_din;
                wr_en_q <= 1'b1;
                state_q <= WR;
              end
            end
          end
        end
        WR: begin
          state_q <= RELEASE;
        end
        RD: begin
          lat_q   <= '0;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
            dout_q  <= fifo.fifo_dout;
            valid_q <= 1'b1;
            state_q <= RELEASE;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        RELEASE: begin
          if (btn_level == 2'b00) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Gating with reset keeps the strobes low in the very cycle reset is first asserted.
  assign fifo.fifo_wr_en = wr_en_q & ~reset;
  assign fifo.fifo_rd_en = rd_en_q & ~reset;
  assign fifo.fifo_din   = din_q;
  assign dout_latched    = dout_q;
  assign dout_valid      = valid_q;
  assign err_overflow    = ovf_q;
  assign err_underflow   = unf_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Self-checking bench for fifo_access_ctrl: expected FIFO strobes and read captures are queued
// as stimulus is applied and matched by a monitor as the DUT produces them.
module tb_fifo_access_ctrl;

  localparam int DW     = 4;
  localparam int EV_WR  = 0;
  localparam int EV_RD  = 1;
  localparam int EV_VAL = 2;

  typedef struct {
    int          kind;
    logic [DW-1:0] data;
  } ev_t;

  logic          clk_5M = 1'b0;
  logic          reset = 1'b1;
  logic          btn_read = 1'b0;
  logic          btn_write = 1'b0;
  logic [DW-1:0] sw_din = '0;
  logic [DW-1:0] dout_latched;
  logic          dout_valid;
  logic          err_overflow;
  logic          err_underflow;
  logic          busy;
  logic [DW-1:0] rd_data = '0;

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  last_rd_cyc = 0;
  ev_t exp_q[$];

  fifo_access_ctrl_if #(.DATA_W(DW)) ifc ();

  fifo_access_ctrl #(
    .DATA_W(DW),
    .DEBOUNCE_CYCLES(4),
    .RD_LATENCY(1)
  ) dut (
    .clk_5M(clk_5M),
    .reset(reset),
    .btn_read(btn_read),
    .btn_write(btn_write),
    .sw_din(sw_din),
    .fifo(ifc),
    .dout_latched(dout_latched),
    .dout_valid(dout_valid),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow),
    .busy(busy)
  );

  always #5 clk_5M = ~clk_5M;

  always @(posedge clk_5M) cyc <= cyc + 1;

  // FIFO model: read data appears one cycle after the sampled read strobe.
  initial ifc.fifo_dout = '0;
  always @(posedge clk_5M) begin
    if (ifc.fifo_rd_en) ifc.fifo_dout <= rd_data;
  end

  // Scoreboard monitor: every strobe or capture pops the next expected event.
  always @(negedge clk_5M) begin
    logic [2:0] seen;
    ev_t e;
    seen = {dout_valid === 1'b1, ifc.fifo_rd_en === 1'b1, ifc.fifo_wr_en === 1'b1};
    if (seen[0] || seen[1]) begin
      n_checks++;
      if (seen[0] && seen[1]) begin
        n_fail++;
        $display("FAIL strobe_overlap: wr_en=1 rd_en=1 at cycle %0d, required at most one", cyc);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (seen[k]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: kind %0d at cycle %0d, required none", k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== k) begin
            n_fail++;
            $display("FAIL event_kind: got kind %0d, required %0d (cycle %0d)", k, e.kind, cyc);
          end else if (k == EV_WR && ifc.fifo_din !== e.data) begin
            n_fail++;
            $display("FAIL wr_data: fifo_din=%h, required %h", ifc.fifo_din, e.data);
          end else if (k == EV_VAL && dout_latched !== e.data) begin
            n_fail++;
            $display("FAIL rd_data: dout_latched=%h, required %h", dout_latched, e.data);
          end else begin
            $display("txn kind=%0d data=%h cycle=%0d ok", k, (k == EV_WR) ? ifc.fifo_din : dout_latched, cyc);
          end
        end
        if (k == EV_RD) last_rd_cyc = cyc;
        if (k == EV_VAL) begin
          n_checks++;
          if (cyc - last_rd_cyc !== 2) begin
            n_fail++;
            $display("FAIL valid_latency: %0d cycles after rd_en, required 2", cyc - last_rd_cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_5M);
  endtask

  task automatic press(input logic w, input logic r, input int hold);
    btn_write = w;
    btn_read  = r;
    step(hold);
    btn_write = 1'b0;
    btn_read  = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_5M);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    n_checks++;
    if ({ifc.fifo_wr_en, ifc.fifo_rd_en, dout_valid, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: wr/rd/valid/busy=%b, required 0000",
               {ifc.fifo_wr_en, ifc.fifo_rd_en, dout_valid, busy});
    end
    n_checks++;
    if ({err_overflow, err_underflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_err: ovf/unf=%b, required 00", {err_overflow, err_underflow});
    end
    n_checks++;
    if ({ifc.fifo_din, dout_latched} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: din=%h dout=%h, required 0 0", ifc.fifo_din, dout_latched);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_write();
    bit ok;
    sw_din = 4'hA;
    ifc.fifo_full = 1'b0;
    exp_q.push_back('{EV_WR, 4'hA});
    press(1'b1, 1'b0, 10);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_busy_held: busy=%b at release, required 1", busy);
    end
    step(3);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_busy_debounce: busy=%b 3 cycles after release, required 1", busy);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL write_idle_timeout: busy=%b, required 0", busy);
    end
    sw_din = 4'h3;
    step(2);
    n_checks++;
    if (ifc.fifo_din !== 4'hA) begin
      n_fail++;
      $display("FAIL write_din_hold: fifo_din=%h, required a", ifc.fifo_din);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL write_missing: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_glitch();
    logic busy_seen;
    logic level_seen;
    busy_seen  = 1'b0;
    level_seen = 1'b0;
    btn_write = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i == 3) btn_write = 1'b0;
      step(1);
      busy_seen  = busy_seen | busy;
      level_seen = level_seen | dut.btn_level[0];
    end
    n_checks++;
    if (busy_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy: busy rose=%b, required 0", busy_seen);
    end
    n_checks++;
    if (level_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_level: debounced level rose=%b, required 0", level_seen);
    end
  endtask

  task automatic test_read();
    bit ok;
    ifc.fifo_empty = 1'b0;
    rd_data = 4'h5;
    exp_q.push_back('{EV_RD, 4'h0});
    exp_q.push_back('{EV_VAL, 4'h5});
    press(1'b0, 1'b1, 10);
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL read_idle_timeout: busy=%b, required 0", busy);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL read_missing: %0d events outstanding, required 0", exp_q.size());
    end
    n_checks++;
    if (dout_latched !== 4'h5) begin
      n_fail++;
      $display("FAIL read_latched: dout_latched=%h, required 5", dout_latched);
    end
  endtask

  task automatic test_errors();
    bit ok;
    ifc.fifo_full = 1'b1;
    press(1'b1, 1'b0, 10);
    wait_idle(ok);
    n_checks++;
    if (!ok || err_overflow !== 1'b1 || err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_flag: ok=%b ovf=%b unf=%b, required 1 1 0", ok, err_overflow, err_underflow);
    end
    ifc.fifo_full  = 1'b0;
    ifc.fifo_empty = 1'b1;
    press(1'b0, 1'b1, 10);
    wait_idle(ok);
    n_checks++;
    if (!ok || err_underflow !== 1'b1 || err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_flag: ok=%b ovf=%b unf=%b, required 1 1 1", ok, err_overflow, err_underflow);
    end
    ifc.fifo_empty = 1'b0;
    step(5);
    n_checks++;
    if ({err_overflow, err_underflow} !== 2'b11) begin
      n_fail++;
      $display("FAIL errors_sticky: ovf/unf=%b, required 11", {err_overflow, err_underflow});
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    ifc.fifo_full  = 1'b0;
    ifc.fifo_empty = 1'b0;
    sw_din  = 4'hC;
    rd_data = 4'h3;
    exp_q.push_back('{EV_WR, 4'hC});
    press(1'b1, 1'b1, 10);
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL both_first: ok=%b outstanding=%0d, required 1 0", ok, exp_q.size());
    end
    exp_q.push_back('{EV_RD, 4'h0});
    exp_q.push_back('{EV_VAL, 4'h3});
    press(1'b1, 1'b1, 10);
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL both_second: ok=%b outstanding=%0d, required 1 0", ok, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    ifc.fifo_empty = 1'b0;
    rd_data = 4'h9;
    exp_q.push_back('{EV_RD, 4'h0});
    seen = 1'b0;
    btn_read = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (ifc.fifo_rd_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    btn_read = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midreset_rd_timeout: rd_en never rose, required a pulse");
    end
    step(1);
    reset = 1'b1;
    step(1);
    n_checks++;
    if ({ifc.fifo_wr_en, ifc.fifo_rd_en, dout_valid, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_ctrl: wr/rd/valid/busy=%b, required 0000",
               {ifc.fifo_wr_en, ifc.fifo_rd_en, dout_valid, busy});
    end
    n_checks++;
    if ({dout_latched, ifc.fifo_din, err_overflow, err_underflow} !== '0) begin
      n_fail++;
      $display("FAIL midreset_data: dout=%h din=%h ovf=%b unf=%b, required all 0",
               dout_latched, ifc.fifo_din, err_overflow, err_underflow);
    end
    step(2);
    reset = 1'b0;
    step(2);
    sw_din = 4'h6;
    exp_q.push_back('{EV_WR, 4'h6});
    press(1'b1, 1'b0, 10);
    wait_idle(ok);
    n_checks++;
    if (!ok || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL midreset_write: ok=%b outstanding=%0d, required 1 0", ok, exp_q.size());
    end
  endtask

  initial begin
    ifc.fifo_full  = 1'b0;
    ifc.fifo_empty = 1'b1;
    test_reset();
    test_write();
    test_glitch();
    test_read();
    test_errors();
    test_simultaneous();
    test_reset_mid();
    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
